spi_burst_write_feeder: RTL and testbench
=========================================

Name: spi_burst_write_feeder

Overview:
Upstream companion to spi_master for burst writes. Holds a small word buffer that the host loads, then runs the master handshake on start. It asserts enable and burst_enable, and answers each o_burst_write_word_request rising edge with the next buffered word. It completes with a done pulse, so the host never has to poll the master.

Parameters:
DEPTH, 16, buffer depth in 16-bit words; power of two, 2..256
AW, 4, buffer address width, log2(DEPTH)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; one clock, synchronous, active-high
i_load_we  in  1  buffer write strobe; honoured only when o_busy=0
i_load_addr  in  AW  buffer write address
i_load_data  in  16  buffer write data
i_start  in  1  start burst; sampled only in IDLE
i_word_count  in  AW+1  words to send N, sampled at start; legal range 1..DEPTH
i_addr  in  15  SPI register address, latched at start
i_spi_busy  in  1  from spi_master o_busy
i_spi_word_request  in  1  from spi_master o_burst_write_word_request
o_spi_data  out  16  to spi_master i_data
o_spi_addr  out  15  to spi_master i_addr
o_spi_rw  out  1  to spi_master i_rw; constant 0 (write)
o_spi_enable  out  1  to spi_master i_enable
o_spi_burst_enable  out  1  to spi_master i_burst_enable
o_spi_burst_count  out  16  to spi_master i_burst_count
o_busy  out  1  high from the start acceptance cycle until done
o_done  out  1  one-cycle pulse at completion
o_overrun  out  1  sticky; set when the master requests more than N-1 words; cleared on next accepted start

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0. Buffer contents are not reset.
- Reset asserted mid-burst returns the block to IDLE at the next edge. o_spi_enable and o_spi_burst_enable drop immediately. The master is not aborted and finishes on its own.
- Buffer: DEPTH x 16, one write port. A load write while o_busy=1 is ignored.
- IDLE:
  - Start with N in 1..DEPTH: latch N and i_addr, set index=0, go to LOAD0, set o_busy=1.
  - Start with N=0 or N>DEPTH: no transfer; o_done pulses the next cycle; o_busy stays 0.
- LOAD0 (1 cycle): o_spi_data=buf[0].
  - N=1: o_spi_burst_enable=0, o_spi_burst_count=0.
  - N>1: o_spi_burst_enable=1, o_spi_burst_count=N-1, zero-extended.
  - Go to ARM.
- ARM: when i_spi_busy=0, assert o_spi_enable and go to WAIT_BUSY.
- WAIT_BUSY: on i_spi_busy=1, deassert o_spi_enable and o_spi_burst_enable. Go to FEED if N>1, else DRAIN.
- FEED: detect the rising edge of i_spi_word_request against a registered copy.
  - On each edge, index++ and o_spi_data=buf[index]. o_spi_data is updated on the clock edge after the request edge is sampled, i.e. latency 1.
  - After N-1 edges, go to DRAIN.
  - If i_spi_busy falls in FEED, go to DRAIN without setting o_overrun. This is an early finish.
- DRAIN:
  - A further request rising edge sets o_overrun; o_spi_data holds the last word.
  - When i_spi_busy=0: pulse o_done, clear o_busy, go to IDLE.
- A request edge and a busy fall in the same cycle: count the request first, then take the busy-fall transition.
- A start while o_busy=1 is ignored.
- Index arithmetic is AW+1 bits and never wraps, because N≤DEPTH.
- o_spi_addr holds the latched address from LOAD0 until the next start.

Decomposition:
- Shared package spi_pkg: state encoding (IDLE, LOAD0, ARM, WAIT_BUSY, FEED, DRAIN) and SPI_DATA_W=16, SPI_ADDR_W=15, SPI_BURST_W=16.
- One sub-module, spi_word_buffer: simple dual-port, write port plus combinational-index read. It is natural to reuse it for a read-side buffer later.

Test Plan:
- Load words 0x0001, 0x0002, 0x0003; start with N=3, addr=0x0AC.
  -> burst_count=2, burst_enable=1, enable pulses until busy. MOSI carries 0x0001, 0x0002, 0x0003 after address 0x0AC. One o_done pulse; o_overrun=0.
- Start with N=1, data 0x00DC.
  -> burst_enable=0, burst_count=0, a single write of 0x00DC, then o_done.
- Start with N=0.
  -> o_done the next cycle, o_spi_enable never asserted, o_busy stays 0.
- N=2 against a master model that issues 2 word requests.
  -> second word sent, o_overrun=1 after DRAIN. The next start clears it.
- Assert a load write to addr 0 with 0xBEEF mid-burst.
  -> ignored; a later burst still sends the original buf[0].
- Assert i_rst during FEED.
  -> next cycle: all outputs 0, state IDLE. After the master goes idle, a new start with N=2 completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI widths and feeder state encoding
// Purpose: common types and widths for the spi_master companion blocks.
// Contents: state_t (feeder FSM states), SPI_DATA_W, SPI_ADDR_W, SPI_BURST_W.
package spi_pkg;

  localparam int SPI_DATA_W  = 16;
  localparam int SPI_ADDR_W  = 15;
  localparam int SPI_BURST_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD0     = 3'd1,
    ARM       = 3'd2,
    WAIT_BUSY = 3'd3,
    FEED      = 3'd4,
    DRAIN     = 3'd5
  } state_t;

endpackage

// File: rtl/spi_word_buffer.sv
// rtl/spi_word_buffer.sv - DEPTH x DW word buffer, one write port, combinational read
// Purpose: small word store; written synchronously, read by index without latency.
// Ports:
//   main_clk        write clock
//   wr_en/addr/data write port
//   rd_addr         read index
//   rd_data         buffer word at rd_addr (combinational)
// Contents are deliberately not reset.
module spi_word_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          main_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge main_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_burst_write_feeder.sv
// rtl/spi_burst_write_feeder.sv - buffered burst-write front end for spi_master
// Purpose: host loads up to DEPTH words, then a start runs the spi_master burst
// handshake, answering each word request with the next buffered word, and ends
// with a one-cycle done pulse.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_load_we/addr/data              host buffer write (ignored while busy)
//   i_start, i_word_count, i_addr    burst request: word count N and register address
//   i_spi_busy, i_spi_word_request   status from spi_master
//   o_spi_*                          request/data toward spi_master
//   o_busy, o_done, o_overrun        host status
module spi_burst_write_feeder
  import spi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load_we,
  input  logic [AW-1:0]          i_load_addr,
  input  logic [SPI_DATA_W-1:0]  i_load_data,
  input  logic                   i_start,
  input  logic [AW:0]            i_word_count,
  input  logic [SPI_ADDR_W-1:0]  i_addr,
  input  logic                   i_spi_busy,
  input  logic                   i_spi_word_request,
  output logic [SPI_DATA_W-1:0]  o_spi_data,
  output logic [SPI_ADDR_W-1:0]  o_spi_addr,
  output logic                   o_spi_rw,
  output logic                   o_spi_enable,
  output logic                   o_spi_burst_enable,
  output logic [SPI_BURST_W-1:0] o_spi_burst_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun
);

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  state_t                state;
  logic [AW:0]           n_words;
  logic [AW:0]           index;
  logic                  req_q;
  logic [AW:0]           index_inc;
  logic [AW:0]           n_m1;
  logic                  req_edge;
  logic                  count_ok;
  logic [AW-1:0]         rd_addr;
  logic [SPI_DATA_W-1:0] rd_data;

  assign o_spi_rw  = 1'b0;
  assign index_inc = index + ONE;
  assign n_m1      = n_words - ONE;
  assign req_edge  = i_spi_word_request & ~req_q;
  assign count_ok  = (i_word_count != '0) && (i_word_count <= DEPTH_N);
  // Look one word ahead so the register can capture buf[index+1] on a request edge.
  assign rd_addr   = (state == LOAD0) ? '0 : index_inc[AW-1:0];

  spi_word_buffer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (SPI_DATA_W)
  ) u_buf (
    .main_clk(i_clk),
    .wr_en   (i_load_we & ~o_busy),
    .wr_addr (i_load_addr),
    .wr_data (i_load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      n_words            <= '0;
      index              <= '0;
      req_q              <= 1'b0;
      o_spi_data         <= '0;
      o_spi_addr         <= '0;
      o_spi_enable       <= 1'b0;
      o_spi_burst_enable <= 1'b0;
      o_spi_burst_count  <= '0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_overrun          <= 1'b0;
    end else begin
      req_q  <= i_spi_word_request;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (count_ok) begin
              n_words    <= i_word_count;
              o_spi_addr <= i_addr;
              index      <= '0;
              o_busy     <= 1'b1;
              o_overrun  <= 1'b0;
              state      <= LOAD0;
            end else begin
              // Unusable count: report completion without touching the master.
              o_done <= 1'b1;
            end
          end
        end
        LOAD0: begin
          o_spi_data         <= rd_data;
          o_spi_burst_enable <= (n_words > ONE);
          o_spi_burst_count  <= {{(SPI_BURST_W-AW-1){1'b0}}, n_m1};
          state              <= ARM;
        end
        ARM: begin
          // A master still finishing an aborted burst must go idle first.
          if (!i_spi_busy) begin
            o_spi_enable <= 1'b1;
            state        <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (i_spi_busy) begin
            o_spi_enable       <= 1'b0;
            o_spi_burst_enable <= 1'b0;
            state              <= (n_words > ONE) ? FEED : DRAIN;
          end
        end
        FEED: begin
          // A request edge is consumed even when busy falls in the same cycle.
          if (req_edge) begin
            index      <= index_inc;
            o_spi_data <= rd_data;
          end
          if (!i_spi_busy || (req_edge && (index_inc == n_m1))) state <= DRAIN;
        end
        DRAIN: begin
          if (req_edge) o_overrun <= 1'b1;
          if (!i_spi_busy) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_write_feeder.sv
// tb/tb_spi_burst_write_feeder.sv - self-checking bench for spi_burst_write_feeder
module tb_spi_burst_write_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          start;
  logic [AW:0]   word_count;
  logic [14:0]   addr;
  logic          spi_busy;
  logic          spi_req;
  logic [15:0]   o_spi_data;
  logic [14:0]   o_spi_addr;
  logic          o_spi_rw;
  logic          o_spi_enable;
  logic          o_spi_burst_enable;
  logic [15:0]   o_spi_burst_count;
  logic          o_busy;
  logic          o_done;
  logic          o_overrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] buf_model [DEPTH];

  spi_burst_write_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_load_we         (load_we),
    .i_load_addr       (load_addr),
    .i_load_data       (load_data),
    .i_start           (start),
    .i_word_count      (word_count),
    .i_addr            (addr),
    .i_spi_busy        (spi_busy),
    .i_spi_word_request(spi_req),
    .o_spi_data        (o_spi_data),
    .o_spi_addr        (o_spi_addr),
    .o_spi_rw          (o_spi_rw),
    .o_spi_enable      (o_spi_enable),
    .o_spi_burst_enable(o_spi_burst_enable),
    .o_spi_burst_count (o_spi_burst_count),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_overrun         (o_overrun)
  );

  task automatic load_word(input int a, input logic [15:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a[AW-1:0]; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    buf_model[a] = d;
  endtask

  // Host start plus a master model that issues 'reqs' word requests, then goes idle.
  // Expected words: word k is buf[k] while k < n, else the last word is held.
  task automatic do_burst(input int n, input logic [14:0] a, input int reqs, input bit poke);
    int t;
    int done_cnt;
    logic [15:0] exp_w;
    logic [15:0] exp_cnt;
    logic        exp_ovr;
    exp_cnt = 16'(n - 1);
    exp_ovr = (reqs > n - 1);
    @(negedge clk);
    start = 1'b1; word_count = n[AW:0]; addr = a;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_overrun !== 1'b0) begin
      $display("FAIL start_accept busy=%b overrun=%b expected busy=1 overrun=0", o_busy, o_overrun); errors++;
    end
    t = 0;
    while (o_spi_enable !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (o_spi_enable !== 1'b1) begin
      $display("FAIL enable_timeout enable=%b expected 1", o_spi_enable); errors++;
    end
    checks++;
    if (o_spi_burst_enable !== (n > 1)) begin
      $display("FAIL burst_enable n=%0d got %b expected %b", n, o_spi_burst_enable, (n > 1)); errors++;
    end
    checks++;
    if (o_spi_burst_count !== exp_cnt) begin
      $display("FAIL burst_count got %h expected %h", o_spi_burst_count, exp_cnt); errors++;
    end
    checks++;
    if (o_spi_addr !== a || o_spi_rw !== 1'b0) begin
      $display("FAIL spi_addr got %h rw %b expected %h rw 0", o_spi_addr, o_spi_rw, a); errors++;
    end
    checks++;
    if (o_spi_data !== buf_model[0]) begin
      $display("FAIL word0 got %h expected %h", o_spi_data, buf_model[0]); errors++;
    end
    spi_busy = 1'b1;
    if (poke) begin load_we = 1'b1; load_addr = '0; load_data = 16'hBEEF; end
    @(negedge clk);
    load_we = 1'b0;
    checks++;
    if (o_spi_enable !== 1'b0 || o_spi_burst_enable !== 1'b0) begin
      $display("FAIL enable_drop enable=%b burst_enable=%b expected 0 0", o_spi_enable, o_spi_burst_enable); errors++;
    end
    for (int k = 1; k <= reqs; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      spi_req = 1'b1;
      @(negedge clk);
      exp_w = buf_model[(k < n) ? k : n - 1];
      checks++;
      if (o_spi_data !== exp_w) begin
        $display("FAIL word%0d got %h expected %h", k, o_spi_data, exp_w); errors++;
      end
      spi_req = 1'b0;
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    spi_busy = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_done === 1'b1) done_cnt++;
      if (o_busy === 1'b0) break;
    end
    @(negedge clk);
    if (o_done === 1'b1) done_cnt++;
    checks++;
    if (done_cnt != 1 || o_busy !== 1'b0) begin
      $display("FAIL done_pulse count=%0d busy=%b expected count=1 busy=0", done_cnt, o_busy); errors++;
    end
    checks++;
    if (o_overrun !== exp_ovr) begin
      $display("FAIL overrun n=%0d reqs=%0d got %b expected %b", n, reqs, o_overrun, exp_ovr); errors++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({o_spi_data, o_spi_addr, o_spi_rw, o_spi_enable, o_spi_burst_enable,
         o_spi_burst_count, o_busy, o_done, o_overrun} !== 53'd0) begin
      $display("FAIL reset_outputs data=%h addr=%h busy=%b expected all zero", o_spi_data, o_spi_addr, o_busy); errors++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_spi_enable !== 1'b0) begin
      $display("FAIL post_reset busy=%b done=%b enable=%b expected 0 0 0", o_busy, o_done, o_spi_enable); errors++;
    end
    for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));
  endtask

  task automatic test_basic();
    load_word(0, 16'h0001); load_word(1, 16'h0002); load_word(2, 16'h0003);
    do_burst(3, 15'h00AC, 2, 1'b0);
  endtask

  task automatic test_single();
    load_word(0, 16'h00DC);
    do_burst(1, 15'h0123, 0, 1'b0);
  endtask

  task automatic test_invalid_count();
    int bad [2];
    bad[0] = 0; bad[1] = DEPTH + 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1; word_count = bad[i][AW:0];
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_spi_enable !== 1'b0) begin
        $display("FAIL invalid_n%0d done=%b busy=%b enable=%b expected 1 0 0", bad[i], o_done, o_busy, o_spi_enable); errors++;
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_spi_enable !== 1'b0) begin
        $display("FAIL invalid_after_n%0d done=%b busy=%b enable=%b expected 0 0 0", bad[i], o_done, o_busy, o_spi_enable); errors++;
      end
    end
  endtask

  task automatic test_overrun();
    load_word(0, 16'h1111); load_word(1, 16'h2222);
    do_burst(2, 15'h0042, 2, 1'b0);
    do_burst(2, 15'h0043, 1, 1'b0);
  endtask

  task automatic test_load_ignored();
    load_word(0, 16'hA5A5);
    do_burst(3, 15'h0010, 2, 1'b1);
    do_burst(1, 15'h0011, 0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int t;
    @(negedge clk);
    start = 1'b1; word_count = 5'd4; addr = 15'h0777;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (o_spi_enable !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    spi_busy = 1'b1;
    repeat (2) @(negedge clk);
    spi_req = 1'b1;
    @(negedge clk);
    spi_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({o_spi_data, o_spi_addr, o_spi_rw, o_spi_enable, o_spi_burst_enable,
         o_spi_burst_count, o_busy, o_done, o_overrun} !== 53'd0) begin
      $display("FAIL reset_mid_burst data=%h addr=%h busy=%b expected all zero", o_spi_data, o_spi_addr, o_busy); errors++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_spi_enable !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL reset_stays_idle enable=%b busy=%b expected 0 0", o_spi_enable, o_busy); errors++;
    end
    spi_busy = 1'b0;
    @(negedge clk);
    do_burst(2, 15'h0778, 1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < 3; j++) load_word($urandom_range(0, DEPTH - 1), 16'($urandom));
      n = $urandom_range(1, DEPTH);
      do_burst(n, 15'($urandom), $urandom_range(0, n), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; word_count = '0; addr = '0; spi_busy = 1'b0; spi_req = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_invalid_count();
    test_overrun();
    test_load_ignored();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
